// File: rtl/counter_ctrl_pkg.sv
// Shared types and defaults for the run/pause counter controller.
package counter_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } ctrl_state_t;

  localparam int WIDTH_DEFAULT      = 64;
  localparam int DEB_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/counter_ctrl_if.sv
// Board-facing signals of counter_ctrl: button/direction in, counter/run flag out.
// state_dbg mirrors the RUN/PAUSE register for checkers and bring-up probes.
interface counter_ctrl_if #(
  parameter int WIDTH = 64
);
  import counter_ctrl_pkg::*;

  logic             btn_n;
  logic             dir;
  logic [WIDTH-1:0] cntr;
  logic             running;
  ctrl_state_t      state_dbg;

  modport master (
    output btn_n,
    output dir,
    input  cntr,
    input  running,
    input  state_dbg
  );

  modport slave (
    input  btn_n,
    input  dir,
    output cntr,
    output running,
    output state_dbg
  );

endinterface

// File: rtl/counter_ctrl_key_debounce.sv
// Two-flop synchroniser and stable-level debouncer for an active-low key;
// emits a one-cycle press pulse on the falling edge of the debounced level.
module key_debounce
  import counter_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int            CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          btn_s;
  logic          level_q;
  logic          level_prev_q;
  logic [CW-1:0] deb_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      btn_s        <= 1'b1;
      level_q      <= 1'b1;
      level_prev_q <= 1'b1;
      deb_cnt_q    <= '0;
    end else begin
      sync1_q      <= btn_n;
      btn_s        <= sync1_q;
      level_prev_q <= level_q;
      // Any sample matching the accepted level restarts the stability window.
      if (btn_s == level_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        level_q   <= btn_s;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + CW'(1);
      end
    end
  end

  assign press = level_prev_q & ~level_q;

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause controller with an up/down counter; a debounced key press toggles RUN/PAUSE.
// Build option: define COUNTER_CTRL_SAT_EN to saturate at 0 / all-ones instead of wrapping.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  counter_ctrl_if.slave  bus
);

  ctrl_state_t      state_q;
  ctrl_state_t      state_d;
  logic [WIDTH-1:0] cntr_q;
  logic [WIDTH-1:0] cntr_d;
  logic             press;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (bus.btn_n),
    .press (press)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cntr_q  <= '0;
    end else begin
      state_q <= state_d;
      cntr_q  <= cntr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (press) state_d = PAUSE;
      PAUSE:   if (press) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Steps on the registered state, so the edge that enters PAUSE still counts once.
  always_comb begin
    cntr_d = cntr_q;
    if (state_q == RUN) begin
`ifdef COUNTER_CTRL_SAT_EN
      if (!bus.dir && (cntr_q != {WIDTH{1'b1}})) begin
        cntr_d = cntr_q + WIDTH'(1);
      end else if (bus.dir && (cntr_q != '0)) begin
        cntr_d = cntr_q - WIDTH'(1);
      end
`else
      if (!bus.dir) begin
        cntr_d = cntr_q + WIDTH'(1);
      end else begin
        cntr_d = cntr_q - WIDTH'(1);
      end
`endif
    end
  end

  assign bus.cntr      = cntr_q;
  assign bus.running   = (state_q == RUN);
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl (WIDTH=8, DEB_CYCLES=4): directed scenarios with literal
// expectations, then random button/direction/reset traffic against a behavioural model.
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  localparam int W   = 8;
  localparam int DEB = 4;
`ifdef COUNTER_CTRL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  counter_ctrl_if #(.WIDTH(W)) bus ();

  counter_ctrl #(
    .WIDTH      (W),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  // The key is seen two edges late; a level is accepted once the delayed key has
  // disagreed with it for DEB edges in a row; an accepted fall toggles run one edge later.
  int            m_cntr;
  bit            m_run;
  bit            m_p1, m_p2, m_lvl, m_press_next;
  int            m_streak;
  logic [W:0]    exp_q[$];

  function automatic int next_count(input int c, input bit down);
    if (SAT) begin
      if (down) return (c == 0) ? 0 : c - 1;
      else      return (c == (1 << W) - 1) ? c : c + 1;
    end
    if (down) return (c + (1 << W) - 1) % (1 << W);
    return (c + 1) % (1 << W);
  endfunction

  always @(posedge clk) begin
    bit obs;
    if (!rst_n) begin
      m_cntr = 0; m_run = 1'b1;
      m_p1 = 1'b1; m_p2 = 1'b1; m_lvl = 1'b1;
      m_streak = 0; m_press_next = 1'b0;
    end else begin
      if (m_run) m_cntr = next_count(m_cntr, bus.dir);
      if (m_press_next) m_run = !m_run;
      obs = m_p2; m_p2 = m_p1; m_p1 = bus.btn_n;
      m_press_next = 1'b0;
      if (obs != m_lvl) begin
        m_streak++;
        if (m_streak == DEB) begin
          m_press_next = m_lvl;   // only a 1 -> 0 acceptance is a press
          m_lvl = obs;
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
    end
    exp_q.push_back({m_run, W'(m_cntr)});
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [W:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cycle_running", 32'(bus.running), 32'(e[W]));
      chk("cycle_cntr", 32'(bus.cntr), 32'(e[W-1:0]));
    end
  end

  // Literal expectations pin both the DUT and the model.
  task automatic pin(input string name, input bit exp_run, input int exp_cntr);
    chk({name, "_dut_running"}, 32'(bus.running), 32'(exp_run));
    chk({name, "_dut_cntr"}, 32'(bus.cntr), 32'(exp_cntr));
    chk({name, "_dut_state"}, 32'(bus.state_dbg == RUN), 32'(exp_run));
    chk({name, "_model_running"}, 32'(m_run), 32'(exp_run));
    chk({name, "_model_cntr"}, 32'(m_cntr), 32'(exp_cntr));
  endtask

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; bus.btn_n = 1'b1; bus.dir = 1'b0;
    step(2);
    rst_n = 1'b1;
    pin("reset", 1'b1, 0);

    step(10);
    pin("free_run", 1'b1, 10);

    // Clean press held 10 edges: toggles at e7, counter steps once more at e7.
    bus.btn_n = 1'b0;
    step(6);
    pin("press_e6", 1'b1, 16);
    step(1);
    pin("press_e7", 1'b0, 17);
    step(3);
    pin("paused_hold", 1'b0, 17);
    bus.btn_n = 1'b1;
    step(8);
    pin("release_no_event", 1'b0, 17);

    // Second press resumes; first step lands on the edge after running rises.
    bus.btn_n = 1'b0;
    step(7);
    pin("resume_e7", 1'b1, 17);
    step(1);
    pin("resume_e8", 1'b1, 18);
    bus.btn_n = 1'b1;
    step(8);
    pin("resume_run", 1'b1, 26);

    // Short glitch is filtered.
    bus.btn_n = 1'b0;
    step(3);
    bus.btn_n = 1'b1;
    step(6);
    pin("glitch", 1'b1, 35);

    // Reset during debounce with the key still held.
    bus.btn_n = 1'b0;
    step(4);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    pin("rst_mid", 1'b1, 0);
    step(6);
    pin("rst_held_no_early", 1'b1, 6);
    step(1);
    pin("rst_held_press", 1'b0, 7);

    // Boundaries at 0 and all-ones.
    bus.btn_n = 1'b1;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    bus.dir = 1'b1;
    step(1);
    pin("wrap_down", 1'b1, SAT ? 0 : 255);
    bus.dir = 1'b0;
    step(1);
    pin("wrap_up_from", 1'b1, SAT ? 1 : 0);
    step(254);
    pin("near_top", 1'b1, SAT ? 255 : 254);
    step(1);
    pin("top", 1'b1, 255);
    step(1);
    pin("over_top", 1'b1, SAT ? 255 : 0);

    // Random traffic, model-checked every cycle.
    for (int r = 0; r < 160; r++) begin
      int len;
      bus.btn_n = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        bus.dir = ($urandom_range(0, 3) == 0);
        rst_n = ($urandom_range(0, 60) != 0);
        step(1);
      end
    end
    rst_n = 1'b1;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
